// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: FSM state encodings,
// parity mode codes and the minimum legal bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int unsigned MIN_PERIOD = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop RX synchroniser (idle high) plus a 3-sample majority vote taken
// at cnt = P-3, P-2 and P-1; vote is meaningful while cnt = P-1.
module uart_rx_sampler #(
    parameter int unsigned PERIOD_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic [PERIOD_WIDTH-1:0] cnt,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    rx_s,
    output logic                    vote
);

    logic [1:0] sync_q;
    logic       samp_a_q;
    logic       samp_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            if (cnt == period - PERIOD_WIDTH'(3)) samp_a_q <= rx_s;
            if (cnt == period - PERIOD_WIDTH'(2)) samp_b_q <= rx_s;
        end
    end

    assign rx_s = sync_q[1];
    // Third sample is the live rx_s at cnt = P-1.
    assign vote = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: 5-9 data bits, runtime parity and stop count,
// one-entry valid/ready output buffer with parity/framing/overrun status.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PERIOD_WIDTH = 20
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [PERIOD_WIDTH-1:0] i_Period,
    input  logic [1:0]              i_Parity_Mode,
    input  logic                    i_Two_Stop,
    input  logic                    i_UART_RX,
    input  logic                    i_Ready,
    input  logic                    i_Clear_Err,
    output logic [DATA_BITS-1:0]    o_Data,
    output logic                    o_Valid,
    output logic                    o_Parity_Err,
    output logic                    o_Frame_Err,
    output logic                    o_Overrun,
    output logic                    o_Busy,
    output logic [2:0]              o_State
);

    rx_state_e               state_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [1:0]              mode_q;
    logic                    two_stop_q;
    logic [DATA_BITS-1:0]    shreg_q;
    logic [3:0]              bit_idx_q;
    logic                    stop_idx_q;
    logic                    perr_q;
    logic                    ferr_q;

    logic rx_s;
    logic vote;
    logic bit_end;
    logic has_par;
    logic can_load;
    logic stop_ferr;

    uart_rx_sampler #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_sampler (
        .clk   (i_Clk),
        .rst   (i_Reset),
        .rx    (i_UART_RX),
        .cnt   (cnt_q),
        .period(period_q),
        .rx_s  (rx_s),
        .vote  (vote)
    );

    assign bit_end   = (cnt_q == period_q - PERIOD_WIDTH'(1));
    assign has_par   = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);
    assign can_load  = !o_Valid || i_Ready;
    assign stop_ferr = ferr_q | ~vote;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            period_q     <= '0;
            mode_q       <= PAR_NONE;
            two_stop_q   <= 1'b0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            o_Data       <= '0;
            o_Valid      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            // Pop and clear first; a load or overrun later in this block wins.
            if (o_Valid && i_Ready) o_Valid <= 1'b0;
            if (i_Clear_Err) o_Overrun <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        period_q   <= i_Period;
                        mode_q     <= i_Parity_Mode;
                        two_stop_q <= i_Two_Stop;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == (period_q >> 1)) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        shreg_q   <= {vote, shreg_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                            state_q <= has_par ? StParity : StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        perr_q  <= vote ^ (^shreg_q) ^ (mode_q == PAR_ODD);
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        cnt_q  <= '0;
                        ferr_q <= stop_ferr;
                        if (two_stop_q && !stop_idx_q) begin
                            stop_idx_q <= 1'b1;
                        end else begin
                            if (can_load) begin
                                o_Data       <= shreg_q;
                                o_Parity_Err <= perr_q;
                                o_Frame_Err  <= stop_ferr;
                                o_Valid      <= 1'b1;
                            end else begin
                                o_Overrun <= 1'b1;
                            end
                            // A line still held low after a bad stop is a break.
                            state_q <= (stop_ferr && !rx_s) ? StBreak : StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                StBreak: begin
                    cnt_q <= '0;
                    if (rx_s) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_Busy  = (state_q != StIdle);
    assign o_State = state_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: frames are serialised on the RX line,
// expected words are queued when driven and compared when the DUT hands them off.
module tb_uart_rx_framed;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned PERIOD_WIDTH = 20;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [PERIOD_WIDTH-1:0] i_Period = 20'd10;
    logic [1:0]              i_Parity_Mode = 2'd0;
    logic                    i_Two_Stop = 1'b0;
    logic                    rx = 1'b1;
    logic                    i_Ready = 1'b1;
    logic                    i_Clear_Err = 1'b0;
    logic [DATA_BITS-1:0]    o_Data;
    logic                    o_Valid;
    logic                    o_Parity_Err;
    logic                    o_Frame_Err;
    logic                    o_Overrun;
    logic                    o_Busy;
    logic [2:0]              o_State;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   valid_cyc = 0;
    bit   saw_break = 1'b0;

    uart_rx_framed #(
        .DATA_BITS   (DATA_BITS),
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Period     (i_Period),
        .i_Parity_Mode(i_Parity_Mode),
        .i_Two_Stop   (i_Two_Stop),
        .i_UART_RX    (rx),
        .i_Ready      (i_Ready),
        .i_Clear_Err  (i_Clear_Err),
        .o_Data       (o_Data),
        .o_Valid      (o_Valid),
        .o_Parity_Err (o_Parity_Err),
        .o_Frame_Err  (o_Frame_Err),
        .o_Overrun    (o_Overrun),
        .o_Busy       (o_Busy),
        .o_State      (o_State)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every accepted word must match the oldest queued frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_State == 3'd5) saw_break = 1'b1;
            if (o_Valid) begin
                valid_cyc++;
                if (i_Ready) begin
                    check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check_eq("data", 32'(o_Data), 32'(e.data));
                        check_eq("perr", 32'(o_Parity_Err), 32'(e.perr));
                        check_eq("ferr", 32'(o_Frame_Err), 32'(e.ferr));
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input int p, input logic [1:0] mode,
                              input logic par_bit, input logic two_stop, input int stop2_low,
                              input int glitch_bit, input bit push);
        exp_t e;
        bit   par_on;
        par_on        = (mode == 2'd1) || (mode == 2'd2);
        i_Period      = PERIOD_WIDTH'(p);
        i_Parity_Mode = mode;
        i_Two_Stop    = two_stop;
        if (push) begin
            e.data = data;
            e.perr = par_on ? (par_bit ^ (^data) ^ (mode == 2'd2)) : 1'b0;
            e.ferr = (stop2_low > 0);
            sb.push_back(e);
        end
        rx = 1'b0;
        wait_cycles(p);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == glitch_bit) begin
                wait_cycles(p / 2);
                rx = ~data[i];
                wait_cycles(1);
                rx = data[i];
                wait_cycles(p - p / 2 - 1);
            end else begin
                wait_cycles(p);
            end
        end
        if (par_on) begin
            rx = par_bit;
            wait_cycles(p);
        end
        rx = 1'b1;
        wait_cycles(p);
        if (two_stop) begin
            if (stop2_low > 0) begin
                rx = 1'b0;
                wait_cycles(stop2_low);
                rx = 1'b1;
            end else begin
                wait_cycles(p);
            end
        end
        wait_cycles(p);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) wait_cycles(1);
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int v0;
        wait_cycles(3);
        check_eq("rst_valid", 32'(o_Valid), 32'd0);
        check_eq("rst_state", 32'(o_State), 32'd0);
        rst = 1'b0;
        wait_cycles(2);
        check_eq("idle_data", 32'(o_Data), 32'd0);
        check_eq("idle_valid", 32'(o_Valid), 32'd0);
        check_eq("idle_busy", 32'(o_Busy), 32'd0);
        check_eq("idle_overrun", 32'(o_Overrun), 32'd0);
        check_eq("idle_state", 32'(o_State), 32'd0);

        // Basic 8N1 at P=10.
        v0 = valid_cyc;
        send_frame(8'hA5, 10, 2'd0, 1'b0, 1'b0, 0, -1, 1'b1);
        wait_drain();
        check_eq("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);

        // Even parity at P=16: correct then wrong parity bit.
        send_frame(8'h07, 16, 2'd1, 1'b1, 1'b0, 0, -1, 1'b1);
        send_frame(8'h07, 16, 2'd1, 1'b0, 1'b0, 0, -1, 1'b1);
        send_frame(8'h07, 16, 2'd2, 1'b0, 1'b0, 0, -1, 1'b1);
        wait_drain();

        // Two stop bits, second held low for 2P: framing error and break.
        saw_break = 1'b0;
        send_frame(8'h3C, 10, 2'd0, 1'b0, 1'b1, 20, -1, 1'b1);
        wait_drain();
        check_eq("saw_break", 32'(saw_break), 32'd1);
        send_frame(8'h11, 10, 2'd0, 1'b0, 1'b1, 0, -1, 1'b1);
        wait_drain();

        // One-clock low glitch while idle: START then back to IDLE.
        v0 = valid_cyc;
        i_Period = 20'd10;
        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(3);
        check_eq("glitch_start", 32'(o_State), 32'd1);
        wait_cycles(20);
        check_eq("glitch_idle", 32'(o_State), 32'd0);
        check_eq("glitch_no_valid", 32'(valid_cyc - v0), 32'd0);

        // One-clock high glitch inside data bit 3 is outvoted.
        send_frame(8'h00, 10, 2'd0, 1'b0, 1'b0, 0, 3, 1'b1);
        wait_drain();

        // Consumer stalled: second frame dropped, overrun set then cleared.
        i_Ready = 1'b0;
        send_frame(8'h55, 10, 2'd0, 1'b0, 1'b0, 0, -1, 1'b1);
        send_frame(8'hAA, 10, 2'd0, 1'b0, 1'b0, 0, -1, 1'b0);
        check_eq("ovr_valid", 32'(o_Valid), 32'd1);
        check_eq("ovr_data", 32'(o_Data), 32'h55);
        check_eq("ovr_flag", 32'(o_Overrun), 32'd1);
        i_Clear_Err = 1'b1;
        wait_cycles(1);
        i_Clear_Err = 1'b0;
        check_eq("ovr_cleared", 32'(o_Overrun), 32'd0);
        i_Ready = 1'b1;
        wait_drain();

        // Reset in the middle of DATA abandons the frame.
        i_Period = 20'd10;
        i_Parity_Mode = 2'd0;
        i_Two_Stop = 1'b0;
        rx = 1'b0;
        wait_cycles(10);
        rx = 1'b1;
        wait_cycles(20);
        check_eq("mid_data_state", 32'(o_State), 32'd2);
        rst = 1'b1;
        wait_cycles(2);
        check_eq("mid_rst_state", 32'(o_State), 32'd0);
        check_eq("mid_rst_data", 32'(o_Data), 32'd0);
        check_eq("mid_rst_valid", 32'(o_Valid), 32'd0);
        check_eq("mid_rst_busy", 32'(o_Busy), 32'd0);
        rst = 1'b0;
        wait_cycles(5);
        send_frame(8'h81, 10, 2'd0, 1'b0, 1'b0, 0, -1, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver: successor to the fixed 8N1 decoder. Supports 5–9 data bits, runtime parity (none/even/odd) and 1 or 2 stop bits, with 3-sample majority voting and an input synchroniser. Delivers each frame through a one-entry valid/ready output buffer carrying parity, framing and overrun status. Sits between the board RX pin and byte consumers such as the echo/TX path and display logic.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PERIOD_WIDTH, 20, width of the bit-period input.
- i_Clk  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Period  in  PERIOD_WIDTH  clocks per bit; minimum 8; captured at start-bit detection.
- i_Parity_Mode  in  2  0 none, 1 even, 2 odd, 3 treated as none; captured at start detect.
- i_Two_Stop  in  1  1 = two stop bits checked; captured at start detect.
- i_UART_RX  in  1  asynchronous serial line, idle high.
- i_Ready  in  1  consumer accepts o_Data when o_Valid=1.
- i_Clear_Err  in  1  clears sticky o_Overrun.
- o_Data  out  DATA_BITS  received word, LSB = first bit on the wire.
- o_Valid  out  1  o_Data and its error flags are valid.
- o_Parity_Err  out  1  parity mismatch on the buffered word; qualified by o_Valid.
- o_Frame_Err  out  1  a stop bit sampled low on the buffered word; qualified by o_Valid.
- o_Overrun  out  1  sticky: a completed frame was dropped because the buffer was full.
- o_Busy  out  1  state is not IDLE.
- o_State  out  3  current state encoding (debug).

## Operation
- RX passes through a 2-flop synchroniser, reset value 1. All sampling uses the synchronised value rx_s.
- States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
- Bit counter cnt: PERIOD_WIDTH bits, cleared on every state entry and after each bit.
- IDLE: when rx_s=0, capture period, parity mode and stop count, clear cnt, go to START.
- START: when cnt=(P>>1), check rx_s. If 0, go to DATA with cnt=0 (aligned to bit centre). If 1, treat as a glitch and return to IDLE.
- Bit sample: vote of rx_s at cnt=P-3, P-2 and P-1. Majority result is taken at cnt=P-1, then cnt is cleared.
- DATA: shift in DATA_BITS votes LSB-first. After the last bit, go to PARITY if the mode is even/odd, else to STOP.
- PARITY: perr = vote XOR (XOR of data) XOR (mode==odd). Then go to STOP.
- STOP: sample 1 or 2 stop bits. Any low stop sample sets ferr.
- End of frame, on the last stop sample: attempt a buffer load. If ferr=1 and rx_s=0, go to BREAK; otherwise go to IDLE.
- BREAK: wait for rx_s=1, then go to IDLE. No new start is detected while in BREAK.
- Buffer load succeeds if o_Valid=0, or if o_Valid=1 and i_Ready=1 in the same cycle (simultaneous pop and push). A successful load writes o_Data, o_Parity_Err and o_Frame_Err and holds o_Valid=1.
- Buffer load fails otherwise: the new frame is discarded, the old word is kept, and o_Overrun is set.
- Pop: o_Valid && i_Ready clears o_Valid unless a load happens in the same cycle.
- o_Overrun clears on i_Clear_Err. If i_Clear_Err and an overrun event coincide, set wins.
- Frames with errors are still delivered, with their flags.
- Reset: all outputs 0, state IDLE, synchroniser at 1. A reset mid-frame abandons the frame, and no word is delivered.

## Timing
- Start-bit falling edge to rx_s low: 2 cycles of synchroniser latency.
- o_Valid rises on the cycle after the final stop-bit vote (cnt=P-1 of the last stop bit).
- Nominal latency from start-bit edge to o_Valid ≈ 2 + P/2 + P·(DATA_BITS + parity + stop).
- Data is accepted on any cycle with o_Valid && i_Ready. o_Data is stable while o_Valid=1 and not popped.
- Changes on i_Period, i_Parity_Mode and i_Two_Stop mid-frame have no effect until the next start bit.
- Counter compare uses full PERIOD_WIDTH equality. P < 8 is illegal and unchecked.

## Structure
- Package uart_pkg holds:
  - state encodings;
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the MIN_PERIOD=8 constant.
- Sub-module uart_rx_sampler: 2-flop synchroniser plus 3-sample majority vote. It outputs rx_s and a vote bit valid at cnt=P-1.
- Top level contains the FSM, shift register, parity accumulator and output buffer.

## Test plan
- DATA_BITS=8, P=10, no parity, 1 stop. Send 0xA5 with i_Ready=1 → o_Data=0xA5, o_Valid pulses 1 cycle, no error flags.
- Even parity, P=16. Send 0x07 with parity bit 1 → o_Parity_Err=0. Repeat with parity bit 0 → o_Parity_Err=1 and o_Data=0x07.
- Two stop bits. Send 0x3C with the second stop bit low for 2P then high → o_Frame_Err=1, state passes through BREAK, and the next 0x11 frame is received cleanly.
- i_Ready=0. Send 0x55 then 0xAA → o_Data stays 0x55 and o_Overrun=1. Pulse i_Clear_Err → o_Overrun=0.
- 1-clock low glitch on RX in IDLE (P=10) → returns to IDLE from START, o_Valid stays 0. A 1-clock high glitch at a data-bit centre is outvoted.
- Assert i_Reset mid-DATA → all outputs 0, state IDLE, and the next full frame 0x81 is received correctly.
